// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 / stride-2 max-pool for a raster-order stream of non-negative binary32 activations.
// A half-row line buffer keeps the even-row horizontal maxima until the matching odd row arrives.
module maxpool2x2_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  frame_done
);

    localparam int CW   = $clog2(IMG_WIDTH);
    localparam int RW   = $clog2(IMG_HEIGHT);
    localparam int HALF = IMG_WIDTH / 2;
    localparam int LBW  = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic [DATA_WIDTH-1:0] pair_reg;
    logic [DATA_WIDTH-1:0] linebuf [HALF];

    logic [DATA_WIDTH-1:0] din_s;
    logic [DATA_WIDTH-1:0] hmax;
    logic [DATA_WIDTH-1:0] vmax;
    logic [LBW-1:0]        lb_idx;
    logic                  col_last;
    logic                  row_last;

    // Both operands are sanitised (sign bit clear), so the magnitude bits order them exactly.
    function automatic logic [DATA_WIDTH-1:0] fmax(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
        return (a[DATA_WIDTH-2:0] >= b[DATA_WIDTH-2:0]) ? a : b;
    endfunction

    assign din_s    = data_in[DATA_WIDTH-1] ? '0 : data_in;
    assign hmax     = fmax(pair_reg, din_s);
    assign lb_idx   = LBW'(col >> 1);
    assign vmax     = fmax(linebuf[lb_idx], hmax);
    assign col_last = (col == CW'(IMG_WIDTH - 1));
    assign row_last = (row == RW'(IMG_HEIGHT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            pair_reg   <= '0;
            out_valid  <= 1'b0;
            data_out   <= '0;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (in_valid) begin
                if (!col[0]) begin
                    pair_reg <= din_s;
                end else if (row[0]) begin
                    data_out   <= vmax;
                    out_valid  <= 1'b1;
                    frame_done <= row_last && col_last;
                end
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    // No reset: every entry is written on an even row before the odd row reads it.
    always_ff @(posedge clk) begin
        if (in_valid && col[0] && !row[0])
            linebuf[lb_idx] <= hmax;
    end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Directed bench for maxpool2x2_stream on a 4x4 map: per-sample output timing, values and frame_done.
module tb_maxpool2x2_stream;

    typedef logic [31:0] frame_t [16];
    typedef logic [31:0] res_t [4];

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] data_in;
    logic        out_valid;
    logic [31:0] data_out;
    logic        frame_done;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic        obs_ov [16];
    logic [31:0] obs_do [16];
    logic        obs_fd [16];
    int          gap_hits;

    frame_t f1 = '{32'h3F800000, 32'h40000000, 32'h3F000000, 32'h40400000,
                   32'h40B33333, 32'h3F000000, 32'h3F800000, 32'h3F800000,
                   32'h00000002, 32'h3F000000, 32'h00000002, 32'h3F000000,
                   32'h00000000, 32'h7F800000, 32'h00000000, 32'h00000000};
    res_t   e1 = '{32'h40B33333, 32'h40400000, 32'h7F800000, 32'h3F000000};

    frame_t f2 = '{32'hC1266666, 32'hC1266666, 32'h80000000, 32'h00000001,
                   32'hC1266666, 32'hC1266666, 32'hBF800000, 32'h80000000,
                   32'h40000000, 32'hC0000000, 32'h7F7FFFFF, 32'h3F800000,
                   32'hC0000000, 32'h3F800000, 32'h00800000, 32'h7F000000};
    res_t   e2 = '{32'h00000000, 32'h00000001, 32'h40000000, 32'h7F7FFFFF};

    maxpool2x2_stream #(.DATA_WIDTH(32), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .data_in    (data_in),
        .out_valid  (out_valid),
        .data_out   (data_out),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1);
    end

    // Drives one frame, `gap` idle cycles after every sample; records outputs 1 cycle after each sample.
    task automatic run_frame(input frame_t f, input int gap);
        gap_hits = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            data_in  = f[i];
            @(posedge clk);
            #1;
            obs_ov[i] = out_valid;
            obs_do[i] = data_out;
            obs_fd[i] = frame_done;
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                in_valid = 1'b0;
                data_in  = 32'hDEADBEEF;
                @(posedge clk);
                #1;
                if (out_valid || frame_done) gap_hits++;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            data_in  = 32'h0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; data_in = 32'h0;
        #12;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else pass_cnt++;
        total_cnt++; if (data_out !== 32'h0) $display("FAIL reset_data_out got %h exp 00000000", data_out); else pass_cnt++;
        total_cnt++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done got %b exp 0", frame_done); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_basic();
        logic e_ov;
        run_frame(f1, 0);
        for (int i = 0; i < 16; i++) begin
            e_ov = ((i / 4) % 2 == 1) && (i % 2 == 1);
            total_cnt++; if (obs_ov[i] !== e_ov) $display("FAIL basic_valid s%0d got %b exp %b", i, obs_ov[i], e_ov); else pass_cnt++;
            if (e_ov) begin
                total_cnt++;
                if (obs_do[i] !== e1[(i / 8) * 2 + (i % 4) / 2]) $display("FAIL basic_data s%0d got %h exp %h", i, obs_do[i], e1[(i / 8) * 2 + (i % 4) / 2]);
                else pass_cnt++;
            end
            total_cnt++; if (obs_fd[i] !== (i == 15)) $display("FAIL basic_frame_done s%0d got %b exp %b", i, obs_fd[i], i == 15); else pass_cnt++;
        end
        idle(2);
    endtask

    task automatic test_negative();
        logic e_ov;
        run_frame(f2, 0);
        for (int i = 0; i < 16; i++) begin
            e_ov = ((i / 4) % 2 == 1) && (i % 2 == 1);
            total_cnt++; if (obs_ov[i] !== e_ov) $display("FAIL neg_valid s%0d got %b exp %b", i, obs_ov[i], e_ov); else pass_cnt++;
            if (e_ov) begin
                total_cnt++;
                if (obs_do[i] !== e2[(i / 8) * 2 + (i % 4) / 2]) $display("FAIL neg_data s%0d got %h exp %h", i, obs_do[i], e2[(i / 8) * 2 + (i % 4) / 2]);
                else pass_cnt++;
            end
        end
        idle(2);
    endtask

    task automatic test_gaps();
        logic e_ov;
        run_frame(f1, 3);
        for (int i = 0; i < 16; i++) begin
            e_ov = ((i / 4) % 2 == 1) && (i % 2 == 1);
            total_cnt++; if (obs_ov[i] !== e_ov) $display("FAIL gap_valid s%0d got %b exp %b", i, obs_ov[i], e_ov); else pass_cnt++;
            if (e_ov) begin
                total_cnt++;
                if (obs_do[i] !== e1[(i / 8) * 2 + (i % 4) / 2]) $display("FAIL gap_data s%0d got %h exp %h", i, obs_do[i], e1[(i / 8) * 2 + (i % 4) / 2]);
                else pass_cnt++;
            end
        end
        total_cnt++; if (gap_hits !== 0) $display("FAIL gap_idle_pulses got %0d exp 0", gap_hits); else pass_cnt++;
        total_cnt++; if (data_out !== 32'h3F000000) $display("FAIL gap_hold got %h exp 3F000000", data_out); else pass_cnt++;
        idle(2);
    endtask

    task automatic test_reset_mid();
        logic e_ov;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            data_in  = 32'h7F000000 + i;
            @(posedge clk);
            #1;
            total_cnt++; if (out_valid !== 1'b0) $display("FAIL rstmid_partial_valid s%0d got %b exp 0", i, out_valid); else pass_cnt++;
        end
        // Sample at row1 col1 arrives together with reset: reset must win.
        @(negedge clk);
        in_valid = 1'b1;
        data_in  = 32'h7F7F0000;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rstmid_valid got %b exp 0", out_valid); else pass_cnt++;
        total_cnt++; if (data_out !== 32'h0) $display("FAIL rstmid_data got %h exp 00000000", data_out); else pass_cnt++;
        total_cnt++; if (frame_done !== 1'b0) $display("FAIL rstmid_frame_done got %b exp 0", frame_done); else pass_cnt++;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_frame(f2, 0);
        for (int i = 0; i < 16; i++) begin
            e_ov = ((i / 4) % 2 == 1) && (i % 2 == 1);
            total_cnt++; if (obs_ov[i] !== e_ov) $display("FAIL rstmid_new_valid s%0d got %b exp %b", i, obs_ov[i], e_ov); else pass_cnt++;
            if (e_ov) begin
                total_cnt++;
                if (obs_do[i] !== e2[(i / 8) * 2 + (i % 4) / 2]) $display("FAIL rstmid_new_data s%0d got %h exp %h", i, obs_do[i], e2[(i / 8) * 2 + (i % 4) / 2]);
                else pass_cnt++;
            end
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        logic e_ov;
        logic [31:0] e_d;
        for (int fr = 0; fr < 2; fr++) begin
            if (fr == 0) run_frame(f1, 0);
            else         run_frame(f2, 0);
            for (int i = 0; i < 16; i++) begin
                e_ov = ((i / 4) % 2 == 1) && (i % 2 == 1);
                e_d  = (fr == 0) ? e1[(i / 8) * 2 + (i % 4) / 2] : e2[(i / 8) * 2 + (i % 4) / 2];
                total_cnt++; if (obs_ov[i] !== e_ov) $display("FAIL b2b_valid f%0d s%0d got %b exp %b", fr, i, obs_ov[i], e_ov); else pass_cnt++;
                if (e_ov) begin
                    total_cnt++; if (obs_do[i] !== e_d) $display("FAIL b2b_data f%0d s%0d got %h exp %h", fr, i, obs_do[i], e_d); else pass_cnt++;
                end
                total_cnt++; if (obs_fd[i] !== (i == 15)) $display("FAIL b2b_frame_done f%0d s%0d got %b exp %b", fr, i, obs_fd[i], i == 15); else pass_cnt++;
            end
        end
        idle(2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_gaps();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
